// File: rtl/vending_pkg.sv
// Shared types and coin constants for the vending machine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    localparam int unsigned COIN_VAL [4] = '{1, 2, 5, 10};

    function automatic int unsigned coin_value(input logic [1:0] coin_type);
        return COIN_VAL[coin_type];
    endfunction

endpackage

// File: rtl/vend_credit_acc.sv
// Credit register: add accepted coins, subtract a price, clear on refund/change.
// Latency: credit and coin_reject update one cycle after the coin/command is sampled.
// Backpressure: none; a coin that cannot be credited is bounced via coin_reject.
module vend_credit_acc #(
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 50
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic                coin_en,
    input  logic [CREDIT_W-1:0] coin_amt,
    input  logic                sub_en,
    input  logic [CREDIT_W-1:0] sub_amt,
    input  logic                clr,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_acc,
    output logic                coin_reject
);

    logic [CREDIT_W:0] sum;

    // One extra bit so the limit check can never be fooled by wrap-around.
    assign sum      = {1'b0, credit} + {1'b0, coin_amt};
    assign coin_acc = coin_valid && coin_en && (sum <= (CREDIT_W+1)'(MAX_CREDIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            credit      <= '0;
            coin_reject <= 1'b0;
        end else begin
            coin_reject <= coin_valid && !coin_acc;
            if (clr)
                credit <= '0;
            else if (sub_en)
                credit <= credit - sub_amt;
            else if (coin_acc)
                credit <= sum[CREDIT_W-1:0];
        end
    end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-coin, multi-item vending controller with change handshake and refund.
// Latency: coin/select/cancel effects appear the cycle after they are sampled.
// Backpressure: change_valid/change_amt held until change_ack; coins are rejected while busy.
module vending_machine_multi
    import vending_pkg::*;
#(
    parameter int                            NUM_ITEMS  = 4,
    parameter int                            CREDIT_W   = 8,
    parameter int                            MAX_CREDIT = 50,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES     = {8'd20, 8'd15, 8'd10, 8'd5}
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         coin_valid,
    input  logic [1:0]                   coin_type,
    input  logic                         select,
    input  logic [$clog2(NUM_ITEMS)-1:0] item_sel,
    input  logic                         cancel,
    input  logic                         change_ack,
    output logic                         disp,
    output logic [$clog2(NUM_ITEMS)-1:0] disp_item,
    output logic                         change_valid,
    output logic [CREDIT_W-1:0]          change_amt,
    output logic [CREDIT_W-1:0]          credit,
    output logic                         coin_reject,
    output logic                         short_funds
);

    localparam int IW = $clog2(NUM_ITEMS);

    state_t              state, state_nxt;
    logic [CREDIT_W-1:0] credit_q;
    logic [CREDIT_W-1:0] price;
    logic [CREDIT_W-1:0] coin_amt;
    logic [IW-1:0]       item_q;
    logic                item_ok, funds_ok;
    logic                open_st, do_cancel, do_select, do_vend, coin_en, coin_acc;

    always_comb begin
        price   = '0;
        item_ok = 1'b0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (int'(item_sel) == i) begin
                price   = PRICES[i*CREDIT_W +: CREDIT_W];
                item_ok = 1'b1;
            end
        end
    end

    // Priority cancel > select > coin; cancel only means something once credit exists.
    assign open_st   = (state == IDLE) || (state == CREDIT);
    assign funds_ok  = item_ok && (credit_q >= price);
    assign do_cancel = (state == CREDIT) && cancel;
    assign do_select = open_st && select && !do_cancel;
    assign do_vend   = do_select && funds_ok;
    assign coin_en   = open_st && !do_cancel && !do_select;
    assign coin_amt  = CREDIT_W'(coin_value(coin_type));

    vend_credit_acc #(
        .CREDIT_W   (CREDIT_W),
        .MAX_CREDIT (MAX_CREDIT)
    ) u_acc (
        .clk         (clk),
        .reset       (reset),
        .coin_valid  (coin_valid),
        .coin_en     (coin_en),
        .coin_amt    (coin_amt),
        .sub_en      (do_vend),
        .sub_amt     (price),
        .clr         (do_cancel || (state == VEND)),
        .credit      (credit_q),
        .coin_acc    (coin_acc),
        .coin_reject (coin_reject)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (coin_acc) state_nxt = CREDIT;
            CREDIT: begin
                if (do_cancel)
                    state_nxt = CHANGE;
                else if (do_vend)
                    state_nxt = VEND;
            end
            VEND:   state_nxt = (credit_q != '0) ? CHANGE : IDLE;
            CHANGE: if (change_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The remainder sits in the credit register during VEND and moves to change_amt on exit.
    always_ff @(posedge clk) begin
        if (reset) begin
            change_amt  <= '0;
            item_q      <= '0;
            short_funds <= 1'b0;
        end else begin
            short_funds <= do_select && !funds_ok;
            if (do_vend)
                item_q <= item_sel;
            if (do_cancel || (state == VEND))
                change_amt <= credit_q;
            else if ((state == CHANGE) && change_ack)
                change_amt <= '0;
        end
    end

    always_comb begin
        disp         = (state == VEND);
        disp_item    = disp ? item_q : '0;
        change_valid = (state == CHANGE);
        credit       = (state == CHANGE) ? '0 : credit_q;
    end

endmodule

// File: tb/tb_vending_machine_multi.sv
// Vector table plus hand-written sequences for vending_machine_multi.
module tb_vending_machine_multi;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type = '0;
    logic       select = 1'b0;
    logic [1:0] item_sel = '0;
    logic       cancel = 1'b0;
    logic       change_ack = 1'b0;
    logic       disp;
    logic [1:0] disp_item;
    logic       change_valid;
    logic [7:0] change_amt;
    logic [7:0] credit;
    logic       coin_reject;
    logic       short_funds;

    always #5 clk = ~clk;

    vending_machine_multi dut (
        .clk          (clk),
        .reset        (reset),
        .coin_valid   (coin_valid),
        .coin_type    (coin_type),
        .select       (select),
        .item_sel     (item_sel),
        .cancel       (cancel),
        .change_ack   (change_ack),
        .disp         (disp),
        .disp_item    (disp_item),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .credit       (credit),
        .coin_reject  (coin_reject),
        .short_funds  (short_funds)
    );

    typedef struct packed {
        logic       disp;
        logic [1:0] disp_item;
        logic       change_valid;
        logic [7:0] change_amt;
        logic [7:0] credit;
        logic       coin_reject;
        logic       short_funds;
    } out_t;

    typedef struct {
        logic       rst;
        logic       cv;
        logic [1:0] ct;
        logic       sel;
        logic [1:0] item;
        logic       can;
        logic       ack;
        out_t       exp;
    } vec_t;

    vec_t vecs[$];
    out_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    function automatic out_t o(int d, int di, int cv, int amt, int cr, int rj, int sf);
        out_t r;
        r.disp         = d[0];
        r.disp_item    = di[1:0];
        r.change_valid = cv[0];
        r.change_amt   = amt[7:0];
        r.credit       = cr[7:0];
        r.coin_reject  = rj[0];
        r.short_funds  = sf[0];
        return r;
    endfunction

    function automatic vec_t mk(int rst, int cv, int ct, int sel, int item, int can, int ack, out_t e);
        vec_t v;
        v.rst  = rst[0];
        v.cv   = cv[0];
        v.ct   = ct[1:0];
        v.sel  = sel[0];
        v.item = item[1:0];
        v.can  = can[0];
        v.ack  = ack[0];
        v.exp  = e;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string nm);
        out_t g, e;
        @(negedge clk);
        reset      = v.rst;
        coin_valid = v.cv;
        coin_type  = v.ct;
        select     = v.sel;
        item_sel   = v.item;
        cancel     = v.can;
        change_ack = v.ack;
        exp_q.push_back(v.exp);
        @(posedge clk);
        #1;
        g = '{disp, disp_item, change_valid, change_amt, credit, coin_reject, short_funds};
        e = exp_q.pop_front();
        // disp_item and change_amt carry meaning only while their qualifier is high.
        if (!e.disp) begin
            g.disp_item = '0;
            e.disp_item = '0;
        end
        if (!e.change_valid && !v.rst) begin
            g.change_amt = '0;
            e.change_amt = '0;
        end
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s got disp=%0d item=%0d cv=%0d amt=%0d credit=%0d rej=%0d sf=%0d want disp=%0d item=%0d cv=%0d amt=%0d credit=%0d rej=%0d sf=%0d",
                     nm, g.disp, g.disp_item, g.change_valid, g.change_amt, g.credit, g.coin_reject, g.short_funds,
                     e.disp, e.disp_item, e.change_valid, e.change_amt, e.credit, e.coin_reject, e.short_funds);
        end
        reset      = 1'b0;
        coin_valid = 1'b0;
        select     = 1'b0;
        cancel     = 1'b0;
        change_ack = 1'b0;
    endtask

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    initial begin
        int n;
        int hold;
        // rst, coin_valid, coin_type, select, item, cancel, ack, expected outputs
        vecs.push_back(mk(1,0,0,0,0,0,0, o(0,0,0,0, 0,0,0)));
        vecs.push_back(mk(0,1,2,0,0,0,0, o(0,0,0,0, 5,0,0)));
        vecs.push_back(mk(0,1,2,0,0,0,0, o(0,0,0,0,10,0,0)));
        vecs.push_back(mk(0,1,3,0,0,0,0, o(0,0,0,0,20,0,0)));
        vecs.push_back(mk(0,0,0,1,1,0,0, o(1,1,0,0,10,0,0)));
        vecs.push_back(mk(0,0,0,0,0,0,0, o(0,0,1,10,0,0,0)));
        vecs.push_back(mk(0,0,0,0,0,0,0, o(0,0,1,10,0,0,0)));
        vecs.push_back(mk(0,0,0,0,0,0,0, o(0,0,1,10,0,0,0)));
        vecs.push_back(mk(0,0,0,0,0,0,1, o(0,0,0,0, 0,0,0)));
        vecs.push_back(mk(0,1,3,0,0,0,0, o(0,0,0,0,10,0,0)));
        vecs.push_back(mk(0,1,2,0,0,0,0, o(0,0,0,0,15,0,0)));
        vecs.push_back(mk(0,0,0,1,2,0,0, o(1,2,0,0, 0,0,0)));
        vecs.push_back(mk(0,0,0,0,0,0,0, o(0,0,0,0, 0,0,0)));
        vecs.push_back(mk(0,0,0,0,0,0,0, o(0,0,0,0, 0,0,0)));
        vecs.push_back(mk(0,0,0,1,0,0,0, o(0,0,0,0, 0,0,1)));
        vecs.push_back(mk(0,0,0,0,0,1,0, o(0,0,0,0, 0,0,0)));
        vecs.push_back(mk(0,1,2,0,0,0,0, o(0,0,0,0, 5,0,0)));
        vecs.push_back(mk(0,0,0,1,3,0,0, o(0,0,0,0, 5,0,1)));
        vecs.push_back(mk(0,0,0,0,0,0,0, o(0,0,0,0, 5,0,0)));
        vecs.push_back(mk(0,0,0,0,0,1,0, o(0,0,1,5, 0,0,0)));
        vecs.push_back(mk(0,1,3,0,0,0,0, o(0,0,1,5, 0,1,0)));
        vecs.push_back(mk(0,0,0,0,0,0,1, o(0,0,0,0, 0,0,0)));
        for (int i = 1; i <= 5; i++)
            vecs.push_back(mk(0,1,3,0,0,0,0, o(0,0,0,0,10*i,0,0)));
        vecs.push_back(mk(0,1,3,0,0,0,0, o(0,0,0,0,50,1,0)));
        vecs.push_back(mk(0,1,0,0,0,0,0, o(0,0,0,0,50,1,0)));
        vecs.push_back(mk(0,0,0,0,0,1,0, o(0,0,1,50,0,0,0)));
        vecs.push_back(mk(0,0,0,0,0,0,1, o(0,0,0,0, 0,0,0)));
        vecs.push_back(mk(0,1,3,0,0,0,0, o(0,0,0,0,10,0,0)));
        vecs.push_back(mk(0,1,3,0,0,0,0, o(0,0,0,0,20,0,0)));
        vecs.push_back(mk(0,1,1,1,0,1,0, o(0,0,1,20,0,1,0)));
        vecs.push_back(mk(0,0,0,0,0,0,0, o(0,0,1,20,0,0,0)));
        vecs.push_back(mk(0,0,0,0,0,0,1, o(0,0,0,0, 0,0,0)));
        vecs.push_back(mk(0,1,3,0,0,0,0, o(0,0,0,0,10,0,0)));
        vecs.push_back(mk(0,0,0,0,0,1,0, o(0,0,1,10,0,0,0)));
        vecs.push_back(mk(1,0,0,0,0,0,0, o(0,0,0,0, 0,0,0)));
        vecs.push_back(mk(0,0,0,0,0,1,0, o(0,0,0,0, 0,0,0)));
        vecs.push_back(mk(0,1,3,0,0,0,0, o(0,0,0,0,10,0,0)));
        vecs.push_back(mk(0,1,0,1,0,0,0, o(1,0,0,0, 5,1,0)));
        vecs.push_back(mk(0,0,0,0,0,0,0, o(0,0,1,5, 0,0,0)));
        vecs.push_back(mk(0,0,0,0,0,0,1, o(0,0,0,0, 0,0,0)));

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("vec%0d", i));

        // Remainder of 2 after buying item 0 with 7; change held for a random time, then acked.
        apply(mk(0,1,2,0,0,0,0, o(0,0,0,0,5,0,0)), "h_coin5");
        apply(mk(0,1,1,0,0,0,0, o(0,0,0,0,7,0,0)), "h_coin2");
        apply(mk(0,0,0,1,0,0,0, o(1,0,0,0,2,0,0)), "h_vend0");
        n = 0;
        while (!change_valid && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("h_change_wait", int'(change_valid), 1);
        chk("h_change_amt", int'(change_amt), 2);
        hold = $urandom_range(2, 6);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            chk("h_change_hold", int'(change_valid) * 100 + int'(change_amt), 102);
        end
        apply(mk(0,0,0,0,0,0,1, o(0,0,0,0,0,0,0)), "h_ack");
        apply(mk(0,0,0,0,0,0,1, o(0,0,0,0,0,0,0)), "h_ack_idle");
        apply(mk(0,1,3,0,0,0,1, o(0,0,0,0,10,0,0)), "h_coin_after_ack");
        apply(mk(0,1,1,1,3,0,0, o(0,0,0,0,10,1,1)), "h_short_with_coin");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vending_machine_multi.md
Name: vending_machine_multi

Overview:
- Parametrised successor to the single-coin, single-product vending machine.
- Accepts four coin denominations and keeps a credit balance; that part of the design supports NUM_ITEMS products with per-item prices set at elaboration.
- Vends the selected item, returns change through a valid/ack handshake, and supports cancel/refund.
- Sits between the coin/keypad front-end and the dispense/change actuators.

Parameters:
- NUM_ITEMS, 4, number of selectable products (>=2).
- CREDIT_W, 8, width of the credit, price and change datapath.
- MAX_CREDIT, 50, highest credit accepted; a coin that would exceed it is rejected.
- PRICES, {8'd20,8'd15,8'd10,8'd5}, flat vector of NUM_ITEMS x CREDIT_W; item 0 occupies the LSBs. Every price must be >0 and <=MAX_CREDIT.

Ports:
- clk  in  1  system clock; rising edge.
- reset  in  1  synchronous, active-high reset.
- coin_valid  in  1  one-cycle strobe: a coin is present.
- coin_type  in  2  coin value when coin_valid=1: 0=1, 1=2, 2=5, 3=10 units.
- select  in  1  one-cycle strobe: purchase request.
- item_sel  in  $clog2(NUM_ITEMS)  item index, sampled with select.
- cancel  in  1  one-cycle strobe: refund the full credit.
- change_ack  in  1  change actuator has taken change_amt.
- disp  out  1  one-cycle dispense pulse.
- disp_item  out  $clog2(NUM_ITEMS)  item being dispensed; valid while disp=1.
- change_valid  out  1  change pending; held high until acked.
- change_amt  out  CREDIT_W  change value; stable while change_valid=1.
- credit  out  CREDIT_W  current balance.
- coin_reject  out  1  one-cycle pulse: the coin was returned, not credited.
- short_funds  out  1  one-cycle pulse: select arrived with credit < price.

Behaviour:
- Reset (synchronous, all states): go to IDLE, credit=0; disp, disp_item, change_valid, change_amt, coin_reject and short_funds all 0.
- Reset wins over every other input.
- Reset mid-vend or mid-change discards the credit or pending change; change_valid falls the cycle after reset is sampled.

States:
- IDLE (credit=0): coin accepted -> CREDIT. select -> short_funds. cancel is ignored.
- CREDIT:
  - Same-cycle priority: cancel > select > coin.
  - cancel -> CHANGE with change_amt=credit.
  - select with credit>=PRICES[item_sel] -> VEND.
  - select with credit<price -> short_funds pulse; stay in CREDIT with credit unchanged.
  - Coin with credit+value<=MAX_CREDIT -> credit+=value.
  - Coin otherwise -> coin_reject.
  - A coin that loses priority to cancel or select in the same cycle -> coin_reject.
- VEND (exactly one cycle):
  - disp=1, disp_item=latched item, credit-=price.
  - Next state: CHANGE if remainder>0, else IDLE.
- CHANGE:
  - change_valid=1, change_amt=remainder, credit output=0.
  - Stay until change_ack=1 is sampled, then IDLE the next cycle.
  - change_ack outside CHANGE is ignored.

Global rules:
- Coins arriving in VEND or CHANGE -> coin_reject.
- select and cancel arriving in VEND or CHANGE are ignored.
- Latency: a coin or select sampled at edge N shows its effect (credit update, disp, or a pulse) in the cycle after edge N.
- Arithmetic: unsigned CREDIT_W. The overflow check uses a CREDIT_W+1-bit sum, so no wrap-around is possible.
- item_sel>=NUM_ITEMS is treated as short_funds and nothing is vended.

Decomposition:
- Package vending_pkg holds:
  - state enum {IDLE, CREDIT, VEND, CHANGE};
  - coin value constants COIN_VAL[0..3] = 1, 2, 5, 10;
  - a coin_value(coin_type) function.
- One sub-module, vend_credit_acc: credit register with add, subtract and clear, the saturation check, and generation of the coin_reject pulse.
- The FSM, price mux and change handshake stay in the top level.

Test Plan:
- Reset mid-CHANGE with change_amt=10 -> change_valid=0 and credit=0 in the following cycle; state IDLE.
- Coins 5,5,10 (credit=20), select item 1 (price 10) -> disp=1 for one cycle with disp_item=1, then change_valid=1 with change_amt=10 held for 3 cycles without ack; ack -> IDLE, credit=0.
- Coins 10,5, select item 2 (price 15) -> disp pulse, change_valid never asserts, credit=0, back to IDLE.
- Coin 5, select item 3 (price 20) -> short_funds pulse, credit stays 5; then cancel -> change_valid=1 with change_amt=5.
- Five 10-unit coins (credit=50), then a sixth 10 -> coin_reject pulse, credit stays 50; then coin 1 -> coin_reject (51>50).
- Credit 20, then cancel, select and coin(2) in the same cycle -> cancel wins: change_amt=20, coin_reject=1, disp=0.
